// File: rtl/ysyx_25060170_gpr_wb_arb.sv
// rtl/ysyx_25060170_gpr_wb_arb.sv - GPR write-back arbiter (EXU/LSU) with pending-write scoreboard
module ysyx_25060170_gpr_wb_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    input  logic              exu_valid,
    input  logic [ADDR_W-1:0] exu_rd,
    input  logic [DATA_W-1:0] exu_wd,
    output logic              exu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_wd,
    output logic              lsu_ready,
    output logic              GPR_we,
    output logic [ADDR_W-1:0] GPR_writer,
    output logic [DATA_W-1:0] GPR_wd,
    input  logic [ADDR_W-1:0] chk_r1,
    input  logic [ADDR_W-1:0] chk_r2,
    output logic              chk_stall,
    output logic              idle
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_set;
    logic [NREG-1:0]   pend_clr;
    logic [NREG-1:0]   pend_next;
    logic              last_lsu;
    logic              grant;
    logic              iss_fire;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_wd;

    // On a tie the source that did not win last time is served; last_lsu resets to 1 so EXU wins first.
    assign exu_ready = exu_valid & (~lsu_valid | last_lsu);
    assign lsu_ready = lsu_valid & (~exu_valid | ~last_lsu);
    assign grant     = exu_ready | lsu_ready;

    assign iss_ready = (iss_rd == '0) | ~pend[iss_rd];
    assign iss_fire  = iss_valid & iss_ready & (iss_rd != '0);

    assign chk_stall = ((chk_r1 != '0) & pend[chk_r1]) | ((chk_r2 != '0) & pend[chk_r2]);
    assign idle      = (pend == '0) & ~GPR_we;

    always_comb begin
        wb_rd     = lsu_rd;
        wb_wd     = lsu_wd;
        pend_set  = '0;
        pend_clr  = '0;
        if (exu_ready) begin
            wb_rd = exu_rd;
            wb_wd = exu_wd;
        end
        if (iss_fire) begin
            pend_set = NREG'(1) << iss_rd;
        end
        if (GPR_we) begin
            pend_clr = NREG'(1) << GPR_writer;
        end
        // Set is applied after clear so a same-edge reissue keeps the bit pending.
        pend_next    = (pend & ~pend_clr) | pend_set;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend       <= '0;
            last_lsu   <= 1'b1;
            GPR_we     <= 1'b0;
            GPR_writer <= '0;
            GPR_wd     <= '0;
        end else begin
            pend <= pend_next;
            if (grant) begin
                last_lsu   <= lsu_ready;
                GPR_we     <= (wb_rd != '0);
                GPR_writer <= wb_rd;
                GPR_wd     <= wb_wd;
            end else begin
                GPR_we <= 1'b0;
            end
        end
    end
endmodule
